pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 3-stage 18-bit processor (IF -> ID -> EX).
//  - Owns the PC; issues instruction-memory fetches.
//  - Drives the IF/ID and ID/EX register load enables and valid bits.
//  - Resolves JMP in decode and stalls the pipe for multi-cycle MUL.
//  - Sits beside Decode and reads its fn/op1 outputs.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/mul_stall_cnt.sv | 42 ++++
 rtl/pipe_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//  Shared definitions for the 3-stage pipeline sequencer:
//  - Decode function codes (FN_ADD / FN_SUB / FN_MUL / FN_JMP)
//  - Sequencer FSM state encodings (IDLE / RUN / MUL_WAIT / DRAIN)
//  - Default PC width and MUL latency
//  No ports; imported by pipe_ctrl and mul_stall_cnt.
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int MUL_LAT_DEF = 3;

    typedef enum logic [1:0] {
        FN_ADD = 2'b00,
        FN_SUB = 2'b01,
        FN_MUL = 2'b10,
        FN_JMP = 2'b11
    } fn_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MUL_WAIT = 2'd2,
        ST_DRAIN    = 2'd3
    } state_e;

endpackage

// File: rtl/mul_stall_cnt.sv
// ----------------------------------------------------------------------------
// mul_stall_cnt
//  Loadable down-counter that times the MUL stall.
//  Ports:
//   clk       in  clock, rising edge
//   rst_n     in  synchronous active-low reset (count -> 0)
//   load      in  load load_val this cycle (has priority over dec)
//   load_val  in  CNT_W value to load
//   dec       in  decrement enable (saturates at 0)
//   last      out count == 1, i.e. the final stall cycle
// ----------------------------------------------------------------------------
module mul_stall_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt_r;

    // Stall counter: load wins, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
//  Sequencer for the 3-stage (IF -> ID -> EX) 18-bit processor. Owns the PC,
//  issues fetches, drives the IF/ID and ID/EX load enables and valid bits,
//  resolves JMP in decode and stalls the pipe while MUL occupies EX.
//  Ports:
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   run              1 = fetch/execute, 0 = stop fetching and drain
//   imem_ready       fetch for pc accepted this cycle
//   dec_fn           decode function code (see fn_e)
//   dec_target       decode op1, jump target when dec_fn = JMP
//   pc               fetch address
//   imem_req         fetch request
//   if_en / id_en    IF/ID and ID/EX register load enables
//   id_valid         IF/ID holds a real instruction
//   ex_valid         ID/EX holds a real instruction
//   mul_start        one-cycle pulse when a MUL enters EX
//   busy             sequencer not idle
//   state            FSM state (debug)
//  Outputs are decoded combinationally from the state and the registers.
// ----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              MUL_LAT  = MUL_LAT_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            imem_ready,
    input  logic [1:0]      dec_fn,
    input  logic [PC_W-1:0] dec_target,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    output logic            if_en,
    output logic            id_en,
    output logic            id_valid,
    output logic            ex_valid,
    output logic            mul_start,
    output logic            busy,
    output logic [1:0]      state
);

    localparam int               CNT_W    = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

    state_e          state_r;
    logic [PC_W-1:0] pc_r;
    logic            id_valid_r;
    logic            ex_valid_r;

    fn_e  fn_s;
    logic is_jmp_s;
    logic imem_req_s;
    logic if_en_s;
    logic id_en_s;
    logic mul_start_s;
    logic cnt_dec_s;
    logic cnt_last_s;

    assign fn_s     = fn_e'(dec_fn);
    assign is_jmp_s = id_valid_r && (fn_s == FN_JMP);

    // Enable decode: RUN fetches and advances, DRAIN only pushes bubbles.
    always_comb begin
        imem_req_s = 1'b0;
        if_en_s    = 1'b0;
        id_en_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                imem_req_s = 1'b1;
                if_en_s    = imem_ready;
                id_en_s    = 1'b1;
            end
            ST_DRAIN: begin
                id_en_s = 1'b1;
            end
            default: begin
                imem_req_s = 1'b0;
                if_en_s    = 1'b0;
                id_en_s    = 1'b0;
            end
        endcase
    end

    // A MUL only counts as started on the cycle it actually moves into EX.
    assign mul_start_s = id_valid_r && (fn_s == FN_MUL) && id_en_s;
    assign cnt_dec_s   = (state_r == ST_MUL_WAIT);

    mul_stall_cnt #(
        .CNT_W (CNT_W)
    ) u_mul_stall_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (mul_start_s),
        .load_val (MUL_LOAD),
        .dec      (cnt_dec_s),
        .last     (cnt_last_s)
    );

    // Sequencer FSM with PC and the two pipeline valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            id_valid_r <= 1'b0;
            ex_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    ex_valid_r <= id_valid_r;
                    // The jump target overrides any fetch accepted this cycle,
                    // and the wrong-path fetch is squashed.
                    if (is_jmp_s) begin
                        pc_r       <= dec_target;
                        id_valid_r <= 1'b0;
                    end else if (imem_ready) begin
                        pc_r       <= pc_r + PC_W'(1);
                        id_valid_r <= 1'b1;
                    end else begin
                        id_valid_r <= 1'b0;
                    end
                    if (mul_start_s) begin
                        state_r <= ST_MUL_WAIT;
                    end else if (!run) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_MUL_WAIT: begin
                    // PC and valid bits stay frozen until the last stall cycle.
                    if (cnt_last_s) begin
                        state_r <= run ? ST_RUN : ST_DRAIN;
                    end else begin
                        state_r <= ST_MUL_WAIT;
                    end
                end
                ST_DRAIN: begin
                    ex_valid_r <= id_valid_r;
                    id_valid_r <= 1'b0;
                    // With IF/ID already empty this edge also empties ID/EX,
                    // so the pipe is clear on arrival in IDLE.
                    if (mul_start_s) begin
                        state_r <= ST_MUL_WAIT;
                    end else if (run) begin
                        state_r <= ST_RUN;
                    end else if (!id_valid_r) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc        = pc_r;
    assign imem_req  = imem_req_s;
    assign if_en     = if_en_s;
    assign id_en     = id_en_s;
    assign id_valid  = id_valid_r;
    assign ex_valid  = ex_valid_r;
    assign mul_start = mul_start_s;
    assign busy      = (state_r != ST_IDLE);
    assign state     = state_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
//  Directed bench for pipe_ctrl (PC_W=8, MUL_LAT=3, RESET_PC=0). The bench
//  plays the role of instruction memory and Decode by driving imem_ready,
//  dec_fn and dec_target. Inputs change 2 time units after a rising edge and
//  outputs are sampled 1 unit later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       imem_ready;
    logic [1:0] dec_fn;
    logic [7:0] dec_target;
    logic [7:0] pc;
    logic       imem_req;
    logic       if_en;
    logic       id_en;
    logic       id_valid;
    logic       ex_valid;
    logic       mul_start;
    logic       busy;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(
        .PC_W     (8),
        .MUL_LAT  (3),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_ready (imem_ready),
        .dec_fn     (dec_fn),
        .dec_target (dec_target),
        .pc         (pc),
        .imem_req   (imem_req),
        .if_en      (if_en),
        .id_en      (id_en),
        .id_valid   (id_valid),
        .ex_valid   (ex_valid),
        .mul_start  (mul_start),
        .busy       (busy),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; returns 2 units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; imem_ready = 1'b1;
        dec_fn = 2'b00; dec_target = 8'h00;
        tick(); tick();
        #1;
        checks++; if (state !== 2'd0)   begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (pc !== 8'h00)     begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc); end
        checks++; if ({id_valid, ex_valid} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", {id_valid, ex_valid}); end
        checks++; if ({imem_req, if_en, id_en, mul_start, busy} !== 5'b00000)
            begin errors++; $display("FAIL reset_outputs: got %b expected 00000", {imem_req, if_en, id_en, mul_start, busy}); end
    endtask

    // reset release with run=1: IDLE for one cycle, then pc 0,1,2,3
    task automatic test_fetch();
        rst_n = 1'b1;
        #1;
        checks++; if (state !== 2'd0 || imem_req !== 1'b0) begin errors++; $display("FAIL fetch_idle: got state=%0d req=%b expected 0/0", state, imem_req); end
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (state !== 2'd1) begin errors++; $display("FAIL fetch_state[%0d]: got %0d expected 1", k, state); end
            checks++; if (pc !== 8'(k))   begin errors++; $display("FAIL fetch_pc[%0d]: got %0h expected %0h", k, pc, k); end
            checks++; if (id_valid !== (k >= 1)) begin errors++; $display("FAIL fetch_id_valid[%0d]: got %b expected %b", k, id_valid, (k >= 1)); end
            checks++; if (ex_valid !== (k >= 2)) begin errors++; $display("FAIL fetch_ex_valid[%0d]: got %b expected %b", k, ex_valid, (k >= 2)); end
            checks++; if ({imem_req, if_en, id_en} !== 3'b111) begin errors++; $display("FAIL fetch_en[%0d]: got %b expected 111", k, {imem_req, if_en, id_en}); end
            tick();
        end
    endtask

    // JMP to 0x40 at pc=4: one squashed slot, then fetch from 0x41
    task automatic test_jmp();
        dec_fn = 2'b11; dec_target = 8'h40;
        #1;
        checks++; if (pc !== 8'h04 || id_valid !== 1'b1) begin errors++; $display("FAIL jmp_pre: got pc=%0h idv=%b expected 4/1", pc, id_valid); end
        tick();
        dec_fn = 2'b00;
        #1;
        checks++; if (pc !== 8'h40)    begin errors++; $display("FAIL jmp_pc: got %0h expected 40", pc); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jmp_squash: got %b expected 0", id_valid); end
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL jmp_ex_noop: got %b expected 1", ex_valid); end
        tick();
        #1;
        checks++; if (pc !== 8'h41 || id_valid !== 1'b1 || ex_valid !== 1'b0)
            begin errors++; $display("FAIL jmp_resume: got pc=%0h idv=%b exv=%b expected 41/1/0", pc, id_valid, ex_valid); end
    endtask

    // MUL at pc=0x41: one mul_start pulse, two frozen cycles, resume
    task automatic test_mul();
        int pulses;
        pulses = 0;
        dec_fn = 2'b10;
        #1;
        checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL mul_start: got %b expected 1", mul_start); end
        if (mul_start === 1'b1) pulses++;
        tick();
        dec_fn = 2'b00;
        for (int k = 0; k < 2; k++) begin
            #1;
            if (mul_start === 1'b1) pulses++;
            checks++; if (state !== 2'd2) begin errors++; $display("FAIL mul_wait_state[%0d]: got %0d expected 2", k, state); end
            checks++; if (pc !== 8'h42)   begin errors++; $display("FAIL mul_wait_pc[%0d]: got %0h expected 42", k, pc); end
            checks++; if ({imem_req, if_en, id_en} !== 3'b000) begin errors++; $display("FAIL mul_wait_en[%0d]: got %b expected 000", k, {imem_req, if_en, id_en}); end
            tick();
        end
        #1;
        if (mul_start === 1'b1) pulses++;
        checks++; if (state !== 2'd1 || if_en !== 1'b1) begin errors++; $display("FAIL mul_resume: got state=%0d if_en=%b expected 1/1", state, if_en); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL mul_pulses: got %0d expected 1", pulses); end
        tick();
        #1;
        checks++; if (pc !== 8'h43) begin errors++; $display("FAIL mul_resume_pc: got %0h expected 43", pc); end
    endtask

    // fetch stalled 2 cycles at pc=5: pc holds, two bubbles reach EX
    task automatic test_imem_stall();
        dec_fn = 2'b11; dec_target = 8'h04;
        tick();
        dec_fn = 2'b00;
        tick();
        #1;
        checks++; if (pc !== 8'h05 || id_valid !== 1'b1) begin errors++; $display("FAIL stall_pre: got pc=%0h idv=%b expected 5/1", pc, id_valid); end
        imem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (if_en !== 1'b0) begin errors++; $display("FAIL stall_if_en[%0d]: got %b expected 0", k, if_en); end
            tick();
            #1;
            checks++; if (pc !== 8'h05 || id_valid !== 1'b0) begin errors++; $display("FAIL stall_hold[%0d]: got pc=%0h idv=%b expected 5/0", k, pc, id_valid); end
            checks++; if (ex_valid !== (k == 0)) begin errors++; $display("FAIL stall_ex[%0d]: got %b expected %b", k, ex_valid, (k == 0)); end
        end
        imem_ready = 1'b1;
        tick();
        #1;
        checks++; if (pc !== 8'h06 || ex_valid !== 1'b0) begin errors++; $display("FAIL stall_bubble2: got pc=%0h exv=%b expected 6/0", pc, ex_valid); end
        tick();
        #1;
        checks++; if (pc !== 8'h07 || ex_valid !== 1'b1) begin errors++; $display("FAIL stall_recover: got pc=%0h exv=%b expected 7/1", pc, ex_valid); end
    endtask

    // pc wrap 0xFF -> 0x00, then run=0 drains to IDLE in two cycles
    task automatic test_wrap_drain();
        dec_fn = 2'b11; dec_target = 8'hFF;
        tick();
        dec_fn = 2'b00;
        #1;
        checks++; if (pc !== 8'hFF || if_en !== 1'b1) begin errors++; $display("FAIL wrap_pre: got pc=%0h if_en=%b expected ff/1", pc, if_en); end
        tick();
        #1;
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %0h expected 0", pc); end
        tick();
        run = 1'b0;
        tick();
        #1;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL drain_state: got %0d expected 3", state); end
        checks++; if ({imem_req, if_en, id_en, busy} !== 4'b0011) begin errors++; $display("FAIL drain_en: got %b expected 0011", {imem_req, if_en, id_en, busy}); end
        checks++; if ({id_valid, ex_valid} !== 2'b11) begin errors++; $display("FAIL drain_valid0: got %b expected 11", {id_valid, ex_valid}); end
        tick();
        #1;
        checks++; if (state !== 2'd3 || {id_valid, ex_valid} !== 2'b01) begin errors++; $display("FAIL drain_step1: got state=%0d v=%b expected 3/01", state, {id_valid, ex_valid}); end
        tick();
        #1;
        checks++; if (state !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL drain_idle: got state=%0d busy=%b expected 0/0", state, busy); end
        checks++; if ({id_valid, ex_valid} !== 2'b00 || pc !== 8'h02) begin errors++; $display("FAIL drain_final: got v=%b pc=%0h expected 00/2", {id_valid, ex_valid}, pc); end
    endtask

    // reset while stalled on a MUL, then no spurious mul_start
    task automatic test_reset_mul();
        int spurious;
        spurious = 0;
        run = 1'b1;
        tick();
        tick();
        dec_fn = 2'b10;
        tick();
        dec_fn = 2'b00;
        #1;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL rmul_wait: got %0d expected 2", state); end
        rst_n = 1'b0;
        tick();
        #1;
        checks++; if (state !== 2'd0 || pc !== 8'h00) begin errors++; $display("FAIL rmul_reset: got state=%0d pc=%0h expected 0/0", state, pc); end
        checks++; if ({imem_req, if_en, id_en, id_valid, ex_valid, mul_start, busy} !== 7'b0000000)
            begin errors++; $display("FAIL rmul_outputs: got %b expected 0000000", {imem_req, if_en, id_en, id_valid, ex_valid, mul_start, busy}); end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (mul_start !== 1'b0) spurious++;
            tick();
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL rmul_spurious: got %0d expected 0", spurious); end
        dec_fn = 2'b10;
        #1;
        checks++; if (mul_start !== 1'b1 || id_valid !== 1'b1) begin errors++; $display("FAIL rmul_new: got ms=%b idv=%b expected 1/1", mul_start, id_valid); end
        tick();
        dec_fn = 2'b00;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_jmp();
        test_mul();
        test_imem_stall();
        test_wrap_drain();
        test_reset_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
